uart_tx_serializer: RTL

Asynchronous serial transmitter that consumes the toggling bit-rate flag produced by the clock-generator counter stage. Every toggle of that flag, rising or falling, is one bit period. The block serializes one parallel word per request into a standard UART frame: start bit, data LSB first, an optional even-parity bit, then stop bit(s). It sits between the processor's memory-mapped UART port and the physical TX pin.

---
 rtl/uart_tx_serializer.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_serializer.sv
// UART frame serializer: start bit, DATA_BITS data LSB first, optional even parity, STOP_BITS stop bits.
// Latency: tx_start accepted on the edge it is seen while idle; start bit begins on the edge after the next baud tick.
// Backpressure: no queueing; tx_start is ignored while busy=1, so the requester must wait for busy=0 or done.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   baud_flag  toggling bit-rate level; every level change is one bit tick
//   tx_start   send request, sampled only while busy=0
//   tx_data    word to send, latched on acceptance
//   tx         serial line, idles high
//   busy       high from the cycle after acceptance until the frame completes
//   done       one-cycle pulse on frame completion
//
// Build option: define UART_TX_PARITY_EN to insert one even-parity bit after the data bits.

module uart_tx_serializer #(
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 baud_flag,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);

    localparam int CW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] LAST_BIT  = CW'(DATA_BITS - 1);
    localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, SYNC, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, SYNC, START, DATA, STOP} state_t;
`endif

    state_t               state_q, state_d;
    logic                 flag_q;
    logic                 tick;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 tx_d, busy_d, done_d;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    // Either edge of the baud level marks one bit period.
    assign tick = baud_flag ^ flag_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            flag_q     <= 1'b0;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            tx         <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            flag_q     <= baud_flag;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            tx         <= tx_d;
            busy       <= busy_d;
            done       <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        tx_d       = tx;
        busy_d     = busy;
        done_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                // A tick arriving with the request is deliberately left for
                // nothing: SYNC waits for the following tick so the start bit
                // is a full bit period long.
                if (tx_start) begin
                    shift_d = tx_data;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^tx_data;
`endif
                    busy_d  = 1'b1;
                    state_d = SYNC;
                end
            end
            SYNC: begin
                if (tick) begin
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    tx_d      = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        tx_d    = parity_q;
                        state_d = PARITY;
`else
                        tx_d       = 1'b1;
                        stop_cnt_d = 1'b0;
                        state_d    = STOP;
`endif
                    end else begin
                        // shift_q already holds the next bit in position 0.
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q + CW'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    tx_d       = 1'b1;
                    stop_cnt_d = 1'b0;
                    state_d    = STOP;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (stop_cnt_q == LAST_STOP) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
